// File: rtl/rtc_bus_if.sv
// Bus-cycle engine for a multiplexed address/data RTC chip: turns a one-cycle
// read or write request into a four-phase CS#/RD#/WR#/A-D# sequence.
module rtc_bus_if #(
    parameter int T_PHASE = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_rd,
    input  logic             start_wr,
    input  logic [7:0]       addr,
    input  logic [7:0]       wdata,
    input  logic [7:0]       ad_in,
    output logic [7:0]       ad_out,
    output logic             ad_oe,
    output logic             cs_n,
    output logic             rd_n,
    output logic             wr_n,
    output logic             ad_n,
    output logic [7:0]       rdata,
    output logic             done,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(T_PHASE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_REL,
        S_DATA,
        S_DATA_REL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic             phaseEnd;

    logic [7:0]       adOut_q, adOut_d;
    logic             adOe_q, adOe_d;
    logic             csN_q, csN_d;
    logic             rdN_q, rdN_d;
    logic             wrN_q, wrN_d;
    logic             adN_q, adN_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        phaseEnd = (cnt_q == LAST);

        case (state_q)
            S_IDLE: begin
                if (start_wr || start_rd) begin
                    state_d = S_ADDR;
                    addr_d  = addr;
                    wdata_d = wdata;
                    wr_d    = start_wr;
                end
            end
            S_ADDR:     if (phaseEnd) state_d = S_ADDR_REL;
            S_ADDR_REL: if (phaseEnd) state_d = S_DATA;
            S_DATA:     if (phaseEnd) state_d = S_DATA_REL;
            S_DATA_REL: if (phaseEnd) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != S_IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Bus outputs are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        csN_d   = !(state_d == S_ADDR || state_d == S_DATA);
        wrN_d   = !(state_d == S_ADDR || (state_d == S_DATA && wr_d));
        rdN_d   = !(state_d == S_DATA && !wr_d);
        adN_d   = (state_d != S_ADDR);
        adOe_d  = 1'b0;
        adOut_d = 8'h00;
        case (state_d)
            S_ADDR, S_ADDR_REL: begin
                adOe_d  = 1'b1;
                adOut_d = addr_d;
            end
            S_DATA, S_DATA_REL: begin
                adOe_d  = wr_d;
                adOut_d = wr_d ? wdata_d : 8'h00;
            end
            default: ;
        endcase
        done_d  = (state_q == S_DATA_REL) && phaseEnd;
        busy_d  = (state_d != S_IDLE);
        rdata_d = ((state_q == S_DATA) && phaseEnd && !wr_q) ? ad_in : rdata_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            wr_q    <= 1'b0;
            adOut_q <= 8'h00;
            adOe_q  <= 1'b0;
            csN_q   <= 1'b1;
            rdN_q   <= 1'b1;
            wrN_q   <= 1'b1;
            adN_q   <= 1'b1;
            rdata_q <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            adOut_q <= adOut_d;
            adOe_q  <= adOe_d;
            csN_q   <= csN_d;
            rdN_q   <= rdN_d;
            wrN_q   <= wrN_d;
            adN_q   <= adN_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign ad_out = adOut_q;
    assign ad_oe  = adOe_q;
    assign cs_n   = csN_q;
    assign rd_n   = rdN_q;
    assign wr_n   = wrN_q;
    assign ad_n   = adN_q;
    assign rdata  = rdata_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_rtc_bus_if.sv
// Self-checking bench for rtc_bus_if: a transaction-level model predicts every
// bus pin from the cycle index within the transaction; directed cases pin it down.
module tb_rtc_bus_if;

    localparam int TP = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start_rd = 1'b0;
    logic       start_wr = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] ad_in = 8'h00;
    logic [7:0] ad_out;
    logic       ad_oe, cs_n, rd_n, wr_n, ad_n, done, busy;
    logic [7:0] rdata;

    int  assertCount = 0;
    int  failCount = 0;
    bit  checkEn = 1'b0;
    bit  fixedEn = 1'b0;

    // Transaction model: mK is the cycle number within the active transaction.
    bit         mActive = 1'b0;
    int         mK = 0;
    bit         mWr = 1'b0;
    logic [7:0] mAddr = 8'h00;
    logic [7:0] mWdata = 8'h00;
    bit         mDone = 1'b0;
    logic [7:0] mRdata = 8'h00;

    rtc_bus_if #(.T_PHASE(TP), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .start_rd(start_rd), .start_wr(start_wr),
        .addr(addr), .wdata(wdata), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n), .rdata(rdata),
        .done(done), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    always @(negedge clock) begin
        ad_in = fixedEn ? 8'h37 : 8'($urandom);
    end

    // Advance the model on each rising edge from the inputs the DUT samples.
    always @(posedge clock) begin
        if (!reset) begin
            mActive = 1'b0;
            mK      = 0;
            mDone   = 1'b0;
            mRdata  = 8'h00;
        end else begin
            mDone = 1'b0;
            if (mActive) begin
                if (mK == 3 * TP && !mWr) mRdata = ad_in;
                if (mK == 4 * TP) begin
                    mActive = 1'b0;
                    mDone   = 1'b1;
                end else begin
                    mK++;
                end
            end else if (start_wr || start_rd) begin
                mActive = 1'b1;
                mK      = 1;
                mWr     = start_wr;
                mAddr   = addr;
                mWdata  = wdata;
            end
        end
    end

    // Compare every pin against the model in mid-cycle.
    always @(negedge clock) begin
        if (checkEn) begin
            int ph;
            bit eCs, eRd, eWr, eAdn, eOe;
            logic [7:0] eOut;
            eCs = 1; eRd = 1; eWr = 1; eAdn = 1; eOe = 0; eOut = 8'h00;
            if (mActive) begin
                ph = (mK - 1) / TP;
                case (ph)
                    0: begin eCs = 0; eWr = 0; eAdn = 0; eOe = 1; eOut = mAddr; end
                    1: begin eOe = 1; eOut = mAddr; end
                    2: begin
                        eCs = 0;
                        if (mWr) begin eWr = 0; eOe = 1; eOut = mWdata; end
                        else eRd = 0;
                    end
                    default: if (mWr) begin eOe = 1; eOut = mWdata; end
                endcase
            end
            checkOutput("cs_n", cs_n, eCs);
            checkOutput("rd_n", rd_n, eRd);
            checkOutput("wr_n", wr_n, eWr);
            checkOutput("ad_n", ad_n, eAdn);
            checkOutput("ad_oe", ad_oe, eOe);
            if (eOe) checkOutput("ad_out", ad_out, eOut);
            checkOutput("busy", busy, mActive);
            checkOutput("done", done, mDone);
            checkOutput("rdata", rdata, mRdata);
        end
    end

    task automatic applyStimulus(input bit wr, input bit rd, input logic [7:0] a, input logic [7:0] d);
        start_wr = wr;
        start_rd = rd;
        addr     = a;
        wdata    = d;
        @(negedge clock);
        start_wr = 1'b0;
        start_rd = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int doneSeen;
        reset    = 1'b0;
        start_wr = 1'b1;
        addr     = 8'hAA;
        wdata    = 8'h55;
        @(posedge clock);
        #1 checkEn = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("rst_cs_n", cs_n, 1);
        checkOutput("rst_ad_oe", ad_oe, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rdata", rdata, 8'h00);
        checkOutput("rst_done", done, 0);
        reset    = 1'b1;
        start_wr = 1'b0;
        waitCycles(1);

        // Directed write
        applyStimulus(1, 0, 8'h21, 8'h45);
        waitCycles(1);
        checkOutput("wr_c2_cs_n", cs_n, 0);
        checkOutput("wr_c2_ad_n", ad_n, 0);
        checkOutput("wr_c2_ad_out", ad_out, 8'h21);
        waitCycles(8);
        checkOutput("wr_c10_wr_n", wr_n, 0);
        checkOutput("wr_c10_ad_n", ad_n, 1);
        checkOutput("wr_c10_ad_out", ad_out, 8'h45);
        waitCycles(6);
        checkOutput("wr_c16_done", done, 0);
        waitCycles(1);
        checkOutput("wr_c17_done", done, 1);
        waitCycles(2);

        // Directed read followed by a back-to-back write
        fixedEn = 1'b1;
        applyStimulus(0, 1, 8'hF0, 8'h00);
        waitCycles(9);
        checkOutput("rd_c10_rd_n", rd_n, 0);
        checkOutput("rd_c10_ad_oe", ad_oe, 0);
        waitCycles(3);
        checkOutput("rd_c13_rdata", rdata, 8'h37);
        waitCycles(4);
        checkOutput("rd_c17_done", done, 1);
        applyStimulus(1, 0, 8'h5A, 8'h99);
        fixedEn = 1'b0;
        checkOutput("b2b_c1_cs_n", cs_n, 0);
        checkOutput("b2b_c1_ad_out", ad_out, 8'h5A);
        waitCycles(16);
        checkOutput("b2b_c17_done", done, 1);
        checkOutput("b2b_rdata", rdata, 8'h37);
        waitCycles(2);

        // Collision plus an ignored read during the transaction
        doneSeen = 0;
        applyStimulus(1, 1, 8'h12, 8'h34);
        waitCycles(5);
        start_rd = 1'b1;
        @(negedge clock);
        start_rd = 1'b0;
        waitCycles(3);
        checkOutput("col_c10_wr_n", wr_n, 0);
        checkOutput("col_c10_rd_n", rd_n, 1);
        for (int i = 0; i < 20; i++) begin
            if (done) doneSeen++;
            @(negedge clock);
        end
        checkOutput("col_done_count", doneSeen, 1);

        // Abort a write by reset in cycle 10
        applyStimulus(1, 0, 8'h77, 8'h88);
        waitCycles(9);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checkOutput("abort_cs_n", cs_n, 1);
        checkOutput("abort_wr_n", wr_n, 1);
        checkOutput("abort_ad_oe", ad_oe, 0);
        doneSeen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) doneSeen++;
            @(negedge clock);
        end
        checkOutput("abort_no_done", doneSeen, 0);
        applyStimulus(0, 1, 8'h3C, 8'h00);
        waitCycles(20);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            int r;
            r        = $urandom_range(0, 9);
            start_rd = (r == 0) || (r == 2);
            start_wr = (r == 1) || (r == 2);
            addr     = 8'($urandom);
            wdata    = 8'($urandom);
            reset    = ($urandom_range(0, 149) != 0);
            @(negedge clock);
        end
        start_rd = 1'b0;
        start_wr = 1'b0;
        reset    = 1'b1;
        waitCycles(20);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
